// File: rtl/lsu_pkg.sv
// Shared types and beat-planning helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Index of the final beat (beat count minus one).
  function automatic logic [1:0] last_beat(input size_e sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_HALF: return 2'd1;
      SZ_WORD: return (addr_lo == 2'b00) ? 2'd0 : 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Only an aligned word travels as a single word beat; everything else is split into bytes.
  function automatic logic is_byte_op(input size_e sz, input logic [1:0] addr_lo);
    return !((sz == SZ_WORD) && (addr_lo == 2'b00));
  endfunction

  // Offset of the last byte touched by an access of this size.
  function automatic logic [1:0] byte_span(input size_e sz);
    case (sz)
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the loaded byte/half/word from the assembly buffer and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  size_e                 size_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned HW = 2 * BYTE_WIDTH;

  always_comb begin
    rdata_o = data_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{(DATA_WIDTH-BYTE_WIDTH){~unsigned_i & data_i[BYTE_WIDTH-1]}},
                          data_i[BYTE_WIDTH-1:0]};
      SZ_HALF: rdata_o = {{(DATA_WIDTH-HW){~unsigned_i & data_i[HW-1]}}, data_i[HW-1:0]};
      default: rdata_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: splits CPU loads/stores into word or byte beats and assembles load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           BYTE_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] END_ADDRESS = 32'h1FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_op_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d, last_q, last_d;
  logic                  we_q, we_d, uns_q, uns_d, bop_q, bop_d, err_q, err_d;
  size_e                 size_q, size_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
  logic [DATA_WIDTH-1:0] ext_rdata;

  size_e                 req_size;
  logic [DATA_WIDTH:0]   span_end;
  logic                  req_err, accept;

  assign req_size = size_e'(req_size_i);
  // 33-bit sum so an access wrapping past the top of the address space is flagged.
  assign span_end = {1'b0, req_addr_i} + (DATA_WIDTH+1)'(byte_span(req_size));
  assign req_err  = (req_size == SZ_BAD) || (span_end > {1'b0, END_ADDRESS});
  assign accept   = (state_q == IDLE) && req_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      bop_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      bop_q   <= bop_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = req_err ? DONE : ACCESS;
      ACCESS:  if (cnt_q == last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    we_d    = we_q;
    uns_d   = uns_q;
    bop_d   = bop_q;
    err_d   = err_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    if (accept) begin
      cnt_d   = '0;
      last_d  = last_beat(req_size, req_addr_i[1:0]);
      we_d    = req_we_i;
      uns_d   = req_unsigned_i;
      bop_d   = is_byte_op(req_size, req_addr_i[1:0]);
      err_d   = req_err;
      size_d  = req_size;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
      buf_d   = '0;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q + 2'd1;
      if (!we_q) begin
        if (bop_q) buf_d[cnt_q*BYTE_WIDTH +: BYTE_WIDTH] = mem_rd_i[BYTE_WIDTH-1:0];
        else       buf_d = mem_rd_i;
      end
    end
  end

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_load_extend (
    .data_i    (buf_q),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .rdata_o   (ext_rdata)
  );

  always_comb begin
    req_ready_o   = (state_q == IDLE);
    resp_valid_o  = 1'b0;
    resp_err_o    = 1'b0;
    resp_rdata_o  = '0;
    mem_we_o      = 1'b0;
    mem_byte_op_o = 1'b0;
    mem_addr_o    = '0;
    mem_wd_o      = '0;
    if (state_q == ACCESS) begin
      mem_we_o      = we_q;
      mem_byte_op_o = bop_q;
      mem_addr_o    = addr_q + DATA_WIDTH'(cnt_q);
      mem_wd_o      = bop_q ? DATA_WIDTH'(wdata_q[cnt_q*BYTE_WIDTH +: BYTE_WIDTH]) : wdata_q;
    end
    if (state_q == DONE) begin
      resp_valid_o = 1'b1;
      resp_err_o   = err_q;
      resp_rdata_o = (we_q || err_q) ? '0 : ext_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model and response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_we_o;
  logic        mem_byte_op_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [0:131071];
  logic [16:0] midx;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .DATA_WIDTH (32),
    .BYTE_WIDTH (8),
    .END_ADDRESS(32'h1FFFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_size_i    (req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .resp_err_o    (resp_err_o),
    .mem_we_o      (mem_we_o),
    .mem_byte_op_o (mem_byte_op_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wd_o      (mem_wd_o),
    .mem_rd_i      (mem_rd_i)
  );

  // Memory model: combinational read, write on the falling edge.
  assign midx = mem_addr_o[16:0];
  always_comb begin
    if (mem_byte_op_o) mem_rd_i = {24'h0, mem[midx]};
    else mem_rd_i = {mem[17'(midx + 17'd3)], mem[17'(midx + 17'd2)],
                     mem[17'(midx + 17'd1)], mem[midx]};
  end

  always @(negedge clk) begin
    if (mem_we_o) begin
      if (mem_byte_op_o) mem[midx] = mem_wd_o[7:0];
      else for (int unsigned i = 0; i < 4; i++) mem[17'(midx + 17'(i))] = mem_wd_o[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid_o) begin
      if (sb.size() == 0) check("resp_without_request", 32'(sb.size()), 32'd1);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata_o, e.rdata);
        check("resp_err", 32'(resp_err_o), 32'(e.err));
      end
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int unsigned k,
                        input logic bop, input logic [31:0] exp_rd, input logic exp_err);
    check($sformatf("%s_ready", tag), 32'(req_ready_o), 32'd1);
    sb.push_back('{exp_rd, exp_err});
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wd;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    for (int unsigned i = 0; i < k; i++) begin
      check($sformatf("%s_b%0d_we", tag, i), 32'(mem_we_o), 32'(we));
      check($sformatf("%s_b%0d_bop", tag, i), 32'(mem_byte_op_o), 32'(bop));
      check($sformatf("%s_b%0d_addr", tag, i), mem_addr_o, addr + i);
      if (we) check($sformatf("%s_b%0d_wd", tag, i), mem_wd_o,
                    bop ? ((wd >> (8*i)) & 32'hFF) : wd);
      @(posedge clk); #1;
    end
    check($sformatf("%s_resp_valid", tag), 32'(resp_valid_o), 32'd1);
    check($sformatf("%s_done_we", tag), 32'(mem_we_o), 32'd0);
    @(posedge clk); #1;
    check($sformatf("%s_resp_pulse", tag), 32'(resp_valid_o), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_err", 32'(resp_err_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_bop", 32'(mem_byte_op_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wd", mem_wd_o, 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req("sw",   1, 2'b10, 0, 32'h10000, 32'hDEADBEEF, 1, 0, 32'h0, 0);
    do_req("lw",   0, 2'b10, 0, 32'h10000, 32'h0,        1, 0, 32'hDEADBEEF, 0);
    do_req("sb80", 1, 2'b00, 0, 32'h10003, 32'hFFFFFF80, 1, 1, 32'h0, 0);
    do_req("lb",   0, 2'b00, 0, 32'h10003, 32'h0,        1, 1, 32'hFFFFFF80, 0);
    do_req("lbu",  0, 2'b00, 1, 32'h10003, 32'h0,        1, 1, 32'h00000080, 0);
    do_req("sh",   1, 2'b01, 0, 32'h10001, 32'h00001234, 2, 1, 32'h0, 0);
    do_req("lh",   0, 2'b01, 0, 32'h10001, 32'h0,        2, 1, 32'h00001234, 0);
    do_req("sh_a", 1, 2'b01, 0, 32'h10002, 32'h00002211, 2, 1, 32'h0, 0);
    do_req("sh_b", 1, 2'b01, 0, 32'h10004, 32'h00004433, 2, 1, 32'h0, 0);
    do_req("lw_mis", 0, 2'b10, 0, 32'h10002, 32'h0,      4, 1, 32'h44332211, 0);
    do_req("sh_neg", 1, 2'b01, 0, 32'h00100, 32'h0000F001, 2, 1, 32'h0, 0);
    do_req("lh_neg", 0, 2'b01, 0, 32'h00100, 32'h0,      2, 1, 32'hFFFFF001, 0);
    do_req("lhu",  0, 2'b01, 1, 32'h00100, 32'h0,        2, 1, 32'h0000F001, 0);
    do_req("lw_oob", 0, 2'b10, 0, 32'h1FFFE, 32'h0,      0, 0, 32'h0, 1);
    do_req("sb_top", 1, 2'b00, 0, 32'h1FFFF, 32'h0000005A, 1, 1, 32'h0, 0);
    do_req("lb_top", 0, 2'b00, 0, 32'h1FFFF, 32'h0,      1, 1, 32'h0000005A, 0);
    do_req("lh_oob", 0, 2'b01, 0, 32'h1FFFF, 32'h0,      0, 0, 32'h0, 1);
    do_req("bad_sz", 0, 2'b11, 0, 32'h10000, 32'h0,      0, 0, 32'h0, 1);
    do_req("sw_wrap", 1, 2'b10, 0, 32'hFFFFFFFE, 32'h12345678, 0, 0, 32'h0, 1);

    // Reset in the middle of a misaligned store.
    do_req("sw_clr", 1, 2'b10, 0, 32'h10000, 32'h000000EF, 1, 0, 32'h0, 0);
    do_req("sb_clr", 1, 2'b00, 0, 32'h10004, 32'h00000000, 1, 1, 32'h0, 0);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = 2'b10;
    req_addr_i  = 32'h10001;
    req_wdata_i = 32'hA1B2C3D4;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("rst6_b0_addr", mem_addr_o, 32'h10001);
    check("rst6_b0_wd", mem_wd_o, 32'h000000D4);
    @(posedge clk); #1;
    check("rst6_b1_addr", mem_addr_o, 32'h10002);
    check("rst6_b1_we", 32'(mem_we_o), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst6_mem_we", 32'(mem_we_o), 32'd0);
    check("rst6_mem_addr", mem_addr_o, 32'd0);
    check("rst6_ready", 32'(req_ready_o), 32'd1);
    check("rst6_resp", 32'(resp_valid_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst6_m1", 32'(mem[17'h10001]), 32'hD4);
    check("rst6_m2", 32'(mem[17'h10002]), 32'hC3);
    check("rst6_m3", 32'(mem[17'h10003]), 32'h00);
    check("rst6_m4", 32'(mem[17'h10004]), 32'h00);
    @(posedge clk); #1;
    check("rst6_no_resp", 32'(resp_valid_o), 32'd0);
    do_req("lw_after", 0, 2'b10, 0, 32'h10000, 32'h0, 1, 0, 32'h00C3D4EF, 0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
